// File: rtl/rf_access_pipe_if.sv
// rf_access_pipe_if: issue, operand-bundle, writeback and status signals of the
// register-file access pipe.
// master = decode/writeback side (drives instructions and writebacks).
// slave  = rf_access_pipe itself.
interface rf_access_pipe_if #(
  parameter int DATA_W = 20,
  parameter int ADDR_W = 4
) ();

  logic              in_valid;
  logic              in_ready;
  logic [1:0]        op_class;
  logic [ADDR_W-1:0] f1;
  logic [ADDR_W-1:0] f2;
  logic [ADDR_W-1:0] f3;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] rd1_data;
  logic [DATA_W-1:0] rd2_data;
  logic [ADDR_W-1:0] dr;
  logic              dr_we;

  logic              wb_en;
  logic              wb_src;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] ram_data;
  logic [DATA_W-1:0] alu_data;

  logic [15:0]       stall_cnt;

  modport master (
    output in_valid, op_class, f1, f2, f3,
    output out_ready,
    output wb_en, wb_src, wb_addr, ram_data, alu_data,
    input  in_ready, out_valid, rd1_data, rd2_data, dr, dr_we, stall_cnt
  );

  modport slave (
    input  in_valid, op_class, f1, f2, f3,
    input  out_ready,
    input  wb_en, wb_src, wb_addr, ram_data, alu_data,
    output in_ready, out_valid, rd1_data, rd2_data, dr, dr_we, stall_cnt
  );

endinterface

// File: rtl/rf_access_pipe.sv
// rf_access_pipe: register file with class-based operand decode, registered
// two-port read, RAM/ALU writeback and a per-register load scoreboard that
// stalls issue on load-use hazards.
// Optional feature macro: RF_BYPASS_EN
//   defined   -> write-first forwarding of same-cycle writeback data, and a
//                clearing RAM writeback masks the hazard on that source.
//   undefined -> reads see the pre-write value; a dependent instruction waits
//                one extra cycle after its load data returns.
module rf_access_pipe #(
  parameter int DATA_W  = 20,
  parameter int REG_CNT = 16,
  parameter int ADDR_W  = 4
) (
  input  logic            clk,
  input  logic            rst,
  rf_access_pipe_if.slave bus
);

  typedef enum logic [1:0] {
    OP_ARITH  = 2'b00,
    OP_LOAD   = 2'b01,
    OP_STORE  = 2'b10,
    OP_BRANCH = 2'b11
  } opClass_e;

  // Register count widened by one bit so it can be compared with any address.
  localparam logic [ADDR_W:0] REG_CNT_L = (ADDR_W + 1)'(REG_CNT);

  function automatic logic addrInRange(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < REG_CNT_L);
  endfunction

  // Architectural state
  logic [DATA_W-1:0]  regFile_q [REG_CNT];
  logic [REG_CNT-1:0] pend_q, pend_d;
  logic [15:0]        stallCnt_q, stallCnt_d;

  // Output bundle register
  logic               outValid_q;
  logic [DATA_W-1:0]  rd1_q, rd2_q;
  logic [ADDR_W-1:0]  dr_q;
  logic               drWe_q;

  // Decode / datapath nets
  opClass_e           opClass;
  logic [ADDR_W-1:0]  src1, src2, drDec;
  logic               drWeDec;
  logic [DATA_W-1:0]  wbData;
  logic               wbWrite, wbClear;
  logic [DATA_W-1:0]  rd1Val, rd2Val;
  logic               pend1, pend2, hz;
  logic               inReady, accept;

  assign opClass = opClass_e'(bus.op_class);

  // Map instruction fields onto source/destination registers by class.
  always_comb begin
    src1    = bus.f2;
    src2    = bus.f3;
    drDec   = bus.f1;
    drWeDec = 1'b1;
    case (opClass)
      OP_ARITH, OP_LOAD: begin
        src1    = bus.f2;
        src2    = bus.f3;
        drDec   = bus.f1;
        drWeDec = 1'b1;
      end
      OP_STORE: begin
        src1    = bus.f1;
        src2    = bus.f3;
        drDec   = bus.f1;
        drWeDec = 1'b0;
      end
      OP_BRANCH: begin
        src1    = bus.f1;
        src2    = bus.f2;
        drDec   = '0;
        drWeDec = 1'b0;
      end
      default: begin
        src1    = bus.f2;
        src2    = bus.f3;
        drDec   = bus.f1;
        drWeDec = 1'b1;
      end
    endcase
  end

  // Writeback data select and qualifiers; out-of-range addresses are dropped.
  always_comb begin
    wbData  = bus.wb_src ? bus.alu_data : bus.ram_data;
    wbWrite = bus.wb_en & addrInRange(bus.wb_addr);
    wbClear = wbWrite & ~bus.wb_src;
  end

  // Read both sources and their scoreboard bits, forwarding when enabled.
  always_comb begin
    rd1Val = addrInRange(src1) ? regFile_q[src1] : '0;
    rd2Val = addrInRange(src2) ? regFile_q[src2] : '0;
    pend1  = addrInRange(src1) & pend_q[src1];
    pend2  = addrInRange(src2) & pend_q[src2];
`ifdef RF_BYPASS_EN
    if (wbWrite && (bus.wb_addr == src1)) begin
      rd1Val = wbData;
    end
    if (wbWrite && (bus.wb_addr == src2)) begin
      rd2Val = wbData;
    end
    if (wbClear && (bus.wb_addr == src1)) begin
      pend1 = 1'b0;
    end
    if (wbClear && (bus.wb_addr == src2)) begin
      pend2 = 1'b0;
    end
`endif
  end

  // Issue handshake: block on hazards and on an unconsumed output bundle.
  always_comb begin
    hz      = pend1 | pend2;
    inReady = ~rst & ~hz & (~outValid_q | bus.out_ready);
    accept  = bus.in_valid & inReady;
  end

  // Scoreboard next state: writeback clear first so a same-cycle load set wins.
  always_comb begin
    pend_d = pend_q;
    if (wbClear) begin
      pend_d[bus.wb_addr] = 1'b0;
    end
    if (accept && (opClass == OP_LOAD) && addrInRange(bus.f1)) begin
      pend_d[bus.f1] = 1'b1;
    end
  end

  // Saturating count of cycles an offered instruction was held by a hazard.
  always_comb begin
    stallCnt_d = stallCnt_q;
    if (bus.in_valid && hz && (stallCnt_q != 16'hFFFF)) begin
      stallCnt_d = stallCnt_q + 16'd1;
    end
  end

  // Register array: reset clears everything and overrides any writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_CNT; i++) begin
        regFile_q[i] <= '0;
      end
    end else if (wbWrite) begin
      regFile_q[bus.wb_addr] <= wbData;
    end
  end

  // Scoreboard and stall counter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= '0;
      stallCnt_q <= '0;
    end else begin
      pend_q     <= pend_d;
      stallCnt_q <= stallCnt_d;
    end
  end

  // Output bundle: load on accept, drop when consumed, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      outValid_q <= 1'b0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      dr_q       <= '0;
      drWe_q     <= 1'b0;
    end else if (accept) begin
      outValid_q <= 1'b1;
      rd1_q      <= rd1Val;
      rd2_q      <= rd2Val;
      dr_q       <= drDec;
      drWe_q     <= drWeDec;
    end else if (outValid_q && bus.out_ready) begin
      outValid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.out_valid = outValid_q;
  assign bus.rd1_data  = rd1_q;
  assign bus.rd2_data  = rd2_q;
  assign bus.dr        = dr_q;
  assign bus.dr_we     = drWe_q;
  assign bus.stall_cnt = stallCnt_q;

endmodule

// File: tb/tb_rf_access_pipe.sv
// tb_rf_access_pipe: directed bench for rf_access_pipe. Expected operand
// bundles are queued at issue and checked by an independent monitor when the
// execute side consumes them. Expectations for the RF_BYPASS_EN build differ
// only in the load-use timing.
module tb_rf_access_pipe;

  localparam int DATA_W = 20;
  localparam int ADDR_W = 4;

  localparam logic [1:0] OP_ARITH  = 2'b00;
  localparam logic [1:0] OP_LOAD   = 2'b01;
  localparam logic [1:0] OP_STORE  = 2'b10;
  localparam logic [1:0] OP_BRANCH = 2'b11;

`ifdef RF_BYPASS_EN
  localparam int STALL_AFTER_LOAD = 2;
`else
  localparam int STALL_AFTER_LOAD = 3;
`endif

  typedef struct packed {
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [ADDR_W-1:0] dr;
    logic              we;
  } bundle_t;

  logic clk = 1'b0;
  logic rst;

  bundle_t expQ[$];
  int      nChecks = 0;
  int      nMiss   = 0;

  rf_access_pipe_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  rf_access_pipe #(.DATA_W(DATA_W), .REG_CNT(16), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    nChecks++;
    if (act !== expv) begin
      nMiss++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    bus.in_valid = 1'b1;
    bus.op_class = op;
    bus.f1       = a;
    bus.f2       = b;
    bus.f3       = c;
  endtask

  task automatic idleIn();
    bus.in_valid = 1'b0;
  endtask

  task automatic writeback(input logic src, input logic [3:0] addr, input logic [19:0] data);
    bus.wb_en   = 1'b1;
    bus.wb_src  = src;
    bus.wb_addr = addr;
    if (src) bus.alu_data = data;
    else     bus.ram_data = data;
  endtask

  task automatic noWriteback();
    bus.wb_en = 1'b0;
  endtask

  task automatic expectBundle(input logic [19:0] r1, input logic [19:0] r2, input logic [3:0] d, input logic w);
    bundle_t b;
    b.rd1 = r1;
    b.rd2 = r2;
    b.dr  = d;
    b.we  = w;
    expQ.push_back(b);
  endtask

  // Monitor: every consumed bundle must match the oldest expectation.
  initial begin
    bundle_t expB;
    forever begin
      @(negedge clk);
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (expQ.size() == 0) begin
          nChecks++;
          nMiss++;
          $display("[TB] FAIL unexpected_bundle: got dr=%h rd1=%h, expected no bundle", bus.dr, bus.rd1_data);
        end else begin
          expB = expQ.pop_front();
          checkOutput("bundle_rd1", 32'(bus.rd1_data), 32'(expB.rd1));
          checkOutput("bundle_rd2", 32'(bus.rd2_data), 32'(expB.rd2));
          checkOutput("bundle_dr",  32'(bus.dr),       32'(expB.dr));
          checkOutput("bundle_we",  32'(bus.dr_we),    32'(expB.we));
        end
      end
    end
  end

  // Watchdog so a wedged design still ends the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op_class  = OP_ARITH;
    bus.f1        = '0;
    bus.f2        = '0;
    bus.f3        = '0;
    bus.out_ready = 1'b1;
    bus.wb_en     = 1'b0;
    bus.wb_src    = 1'b0;
    bus.wb_addr   = '0;
    bus.ram_data  = '0;
    bus.alu_data  = '0;

    // Reset state
    repeat (2) cycle();
    checkOutput("reset_in_ready",  32'(bus.in_ready),  0);
    checkOutput("reset_out_valid", 32'(bus.out_valid), 0);
    checkOutput("reset_stall_cnt", 32'(bus.stall_cnt), 0);
    checkOutput("reset_dr",        32'(bus.dr),        0);
    checkOutput("reset_dr_we",     32'(bus.dr_we),     0);
    checkOutput("reset_rd1",       32'(bus.rd1_data),  0);
    rst = 1'b0;
    #1;
    checkOutput("post_reset_in_ready", 32'(bus.in_ready), 1);

    // ALU writeback then arith read of it
    writeback(1'b1, 4'd3, 20'h12345);
    cycle();
    noWriteback();
    applyStimulus(OP_ARITH, 4'd5, 4'd3, 4'd0);
    expectBundle(20'h12345, 20'h0, 4'd5, 1'b1);
    #1;
    checkOutput("arith_in_ready", 32'(bus.in_ready), 1);
    cycle();
    idleIn();
    checkOutput("arith_out_valid", 32'(bus.out_valid), 1);

    // Store and branch decode
    writeback(1'b1, 4'd2, 20'hAAAAA);
    cycle();
    writeback(1'b0, 4'd4, 20'h00010);
    cycle();
    noWriteback();
    applyStimulus(OP_STORE, 4'd2, 4'd7, 4'd4);
    expectBundle(20'hAAAAA, 20'h00010, 4'd2, 1'b0);
    cycle();
    applyStimulus(OP_BRANCH, 4'd2, 4'd4, 4'd9);
    expectBundle(20'hAAAAA, 20'h00010, 4'd0, 1'b0);
    cycle();
    idleIn();
    cycle();

    // Load-use hazard on r6
    applyStimulus(OP_LOAD, 4'd6, 4'd1, 4'd1);
    expectBundle(20'h0, 20'h0, 4'd6, 1'b1);
    cycle();
    applyStimulus(OP_ARITH, 4'd7, 4'd6, 4'd0);
    #1;
    checkOutput("hazard_in_ready", 32'(bus.in_ready), 0);
    cycle();
    checkOutput("stall_cnt_1", 32'(bus.stall_cnt), 1);
    cycle();
    checkOutput("stall_cnt_2", 32'(bus.stall_cnt), 2);
    checkOutput("hazard_in_ready_2", 32'(bus.in_ready), 0);
    writeback(1'b0, 4'd6, 20'h0BEEF);
    #1;
`ifdef RF_BYPASS_EN
    checkOutput("bypass_in_ready", 32'(bus.in_ready), 1);
    expectBundle(20'h0BEEF, 20'h0, 4'd7, 1'b1);
    cycle();
    noWriteback();
    idleIn();
`else
    checkOutput("nobypass_in_ready_wb", 32'(bus.in_ready), 0);
    cycle();
    noWriteback();
    #1;
    checkOutput("nobypass_in_ready_next", 32'(bus.in_ready), 1);
    expectBundle(20'h0BEEF, 20'h0, 4'd7, 1'b1);
    cycle();
    idleIn();
`endif
    checkOutput("stall_cnt_after_load", 32'(bus.stall_cnt), STALL_AFTER_LOAD);
    cycle();

    // Backpressure: bundle held, issue blocked, then same-cycle release
    bus.out_ready = 1'b0;
    applyStimulus(OP_ARITH, 4'd8, 4'd3, 4'd2);
    expectBundle(20'h12345, 20'hAAAAA, 4'd8, 1'b1);
    cycle();
    applyStimulus(OP_BRANCH, 4'd3, 4'd6, 4'd0);
    expectBundle(20'h12345, 20'h0BEEF, 4'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("hold_in_ready",  32'(bus.in_ready),  0);
      checkOutput("hold_out_valid", 32'(bus.out_valid), 1);
      checkOutput("hold_rd1",       32'(bus.rd1_data),  32'h12345);
      checkOutput("hold_rd2",       32'(bus.rd2_data),  32'hAAAAA);
      checkOutput("hold_dr",        32'(bus.dr),        8);
      cycle();
    end
    bus.out_ready = 1'b1;
    #1;
    checkOutput("release_in_ready", 32'(bus.in_ready), 1);
    cycle();
    idleIn();
    cycle();

    // Load set beats same-cycle RAM clear on r6
    applyStimulus(OP_LOAD, 4'd6, 4'd0, 4'd0);
    writeback(1'b0, 4'd6, 20'h11111);
    expectBundle(20'h0, 20'h0, 4'd6, 1'b1);
    #1;
    checkOutput("load_clear_in_ready", 32'(bus.in_ready), 1);
    cycle();
    noWriteback();
    applyStimulus(OP_ARITH, 4'd9, 4'd6, 4'd0);
    #1;
    checkOutput("set_wins_in_ready", 32'(bus.in_ready), 0);
    cycle();
    checkOutput("set_wins_stall_cnt", 32'(bus.stall_cnt), STALL_AFTER_LOAD + 1);

    // Reset mid-stall
    rst = 1'b1;
    #1;
    checkOutput("rst_in_ready", 32'(bus.in_ready), 0);
    cycle();
    rst = 1'b0;
    checkOutput("midrst_out_valid", 32'(bus.out_valid), 0);
    checkOutput("midrst_stall_cnt", 32'(bus.stall_cnt), 0);
    #1;
    checkOutput("midrst_in_ready", 32'(bus.in_ready), 1);
    expectBundle(20'h0, 20'h0, 4'd9, 1'b1);
    cycle();
    idleIn();
    checkOutput("midrst_accept_valid", 32'(bus.out_valid), 1);
    repeat (3) cycle();

    checkOutput("scoreboard_drained", 32'(expQ.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nMiss);
    $finish;
  end

endmodule
